even_odd_decoder: RTL and testbench

EVEN_ODD_DECODER -- requirements
Module: even_odd_decoder

---
 rtl/even_odd_decoder.sv | 150 +++++++++++++++
 tb/tb_even_odd_decoder.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/even_odd_decoder.sv
// even_odd_decoder
//   Recovers a data bit from a stream of tagged 4-bit words. Each word is
//   in[3:1] = 3-bit sequence tag, in[0] = data bit. A HUNT/CHECK/LOCKED
//   state machine acquires sequence lock after LOCK_CNT consecutive
//   in-sequence words. While LOCKED it accepts in-sequence words and counts
//   out-of-sequence ones. After LOSS_CNT consecutive misses it drops back
//   to HUNT.
//
// Ports
//   clk        : single clock, all logic on posedge
//   rst        : synchronous active-high reset, overrides all other inputs
//   in[3:0]    : tagged word (tag in [3:1], data in [0])
//   in_valid   : in is sampled only when high
//   clr_stats  : synchronous clear of err_cnt/one_cnt/zero_cnt
//   data_out   : data bit of the last accepted word
//   data_valid : one-cycle pulse when data_out/seq_out carry a new word
//   seq_out    : tag of the last accepted word
//   locked     : high while in LOCKED
//   err_cnt    : saturating count of out-of-sequence words seen in LOCKED
//   one_cnt    : saturating count of accepted 1 bits
//   zero_cnt   : saturating count of accepted 0 bits
module even_odd_decoder #(
  parameter int LOCK_CNT = 2,
  parameter int LOSS_CNT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] in,
  input  logic       in_valid,
  input  logic       clr_stats,
  output logic       data_out,
  output logic       data_valid,
  output logic [2:0] seq_out,
  output logic       locked,
  output logic [7:0] err_cnt,
  output logic [7:0] one_cnt,
  output logic [7:0] zero_cnt
);

  localparam logic [2:0] LOCK_N = 3'(LOCK_CNT);
  localparam logic [2:0] LOSS_N = 3'(LOSS_CNT);

  typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;

  state_t     state, state_nxt;
  logic [2:0] exp_seq, exp_nxt;
  logic [2:0] match_cnt, match_nxt;
  logic [2:0] miss_cnt, miss_nxt;
  logic       dout_nxt, dv_nxt, lock_nxt;
  logic [2:0] seq_nxt;
  logic       err_inc, one_inc, zero_inc;
  logic [7:0] err_nxt, one_nxt, zero_nxt;
  logic [2:0] tag;

  // Increment that sticks at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic inc);
    if (inc && v != 8'hFF) return v + 8'd1;
    return v;
  endfunction

  assign tag = in[3:1];

  always_comb begin
    state_nxt = state;
    exp_nxt   = exp_seq;
    match_nxt = match_cnt;
    miss_nxt  = miss_cnt;
    dout_nxt  = data_out;
    seq_nxt   = seq_out;
    dv_nxt    = 1'b0;
    err_inc   = 1'b0;
    one_inc   = 1'b0;
    zero_inc  = 1'b0;
    if (in_valid) begin
      unique case (state)
        HUNT: begin
          exp_nxt   = tag + 3'd1;
          match_nxt = 3'd1;
          state_nxt = (LOCK_N == 3'd1) ? LOCKED : CHECK;
        end
        CHECK: begin
          if (tag == exp_seq) begin
            match_nxt = match_cnt + 3'd1;
            exp_nxt   = exp_seq + 3'd1;
            if (match_cnt + 3'd1 >= LOCK_N) state_nxt = LOCKED;
          end else begin
            // Resynchronise on the new tag without touching err_cnt.
            exp_nxt   = tag + 3'd1;
            match_nxt = 3'd1;
          end
        end
        LOCKED: begin
          // Flywheel: the expected tag advances whether or not the word matched.
          exp_nxt = exp_seq + 3'd1;
          if (tag == exp_seq) begin
            dv_nxt   = 1'b1;
            dout_nxt = in[0];
            seq_nxt  = tag;
            miss_nxt = 3'd0;
            one_inc  = in[0];
            zero_inc = ~in[0];
          end else begin
            err_inc = 1'b1;
            if (miss_cnt + 3'd1 >= LOSS_N) begin
              state_nxt = HUNT;
              miss_nxt  = 3'd0;
            end else begin
              miss_nxt = miss_cnt + 3'd1;
            end
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
    lock_nxt = (state_nxt == LOCKED);
    // A clear wins over any increment arriving in the same cycle.
    err_nxt  = clr_stats ? 8'd0 : sat_inc(err_cnt, err_inc);
    one_nxt  = clr_stats ? 8'd0 : sat_inc(one_cnt, one_inc);
    zero_nxt = clr_stats ? 8'd0 : sat_inc(zero_cnt, zero_inc);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HUNT;
      exp_seq    <= 3'd0;
      match_cnt  <= 3'd0;
      miss_cnt   <= 3'd0;
      data_out   <= 1'b0;
      data_valid <= 1'b0;
      seq_out    <= 3'd0;
      locked     <= 1'b0;
      err_cnt    <= 8'd0;
      one_cnt    <= 8'd0;
      zero_cnt   <= 8'd0;
    end else begin
      state      <= state_nxt;
      exp_seq    <= exp_nxt;
      match_cnt  <= match_nxt;
      miss_cnt   <= miss_nxt;
      data_out   <= dout_nxt;
      data_valid <= dv_nxt;
      seq_out    <= seq_nxt;
      locked     <= lock_nxt;
      err_cnt    <= err_nxt;
      one_cnt    <= one_nxt;
      zero_cnt   <= zero_nxt;
    end
  end

endmodule

// File: tb/tb_even_odd_decoder.sv
// tb_even_odd_decoder
//   Directed bench for even_odd_decoder with default parameters
//   (LOCK_CNT=2, LOSS_CNT=2). Inputs change on the falling edge; outputs are
//   sampled 1 time unit after the rising edge that registers the word.
module tb_even_odd_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] in = 4'h0;
  logic       in_valid = 1'b0;
  logic       clr_stats = 1'b0;
  logic       data_out, data_valid, locked;
  logic [2:0] seq_out;
  logic [7:0] err_cnt, one_cnt, zero_cnt;

  int checks = 0;
  int failures = 0;

  even_odd_decoder dut (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .clr_stats(clr_stats),
    .data_out(data_out), .data_valid(data_valid), .seq_out(seq_out),
    .locked(locked), .err_cnt(err_cnt), .one_cnt(one_cnt), .zero_cnt(zero_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [3:0] w, input logic v, input logic c, input logic r);
    @(negedge clk);
    in = w; in_valid = v; clr_stats = c; rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic dv, input logic lk,
                         input logic [2:0] sq, input logic d);
    chk({tag, ".dv"}, 32'(data_valid), 32'(dv));
    chk({tag, ".locked"}, 32'(locked), 32'(lk));
    chk({tag, ".seq"}, 32'(seq_out), 32'(sq));
    chk({tag, ".dout"}, 32'(data_out), 32'(d));
  endtask

  task automatic chk_cnt(input string tag, input int e, input int o, input int z);
    chk({tag, ".err"}, 32'(err_cnt), 32'(e));
    chk({tag, ".one"}, 32'(one_cnt), 32'(o));
    chk({tag, ".zero"}, 32'(zero_cnt), 32'(z));
  endtask

  initial begin
    logic [2:0] t;
    // Reset with clr_stats and a valid word present: reset must win.
    send(4'hF, 1'b1, 1'b1, 1'b1);
    send(4'hF, 1'b1, 1'b1, 1'b1);
    chk_out("reset", 1'b0, 1'b0, 3'd0, 1'b0);
    chk_cnt("reset", 0, 0, 0);

    // Lock acquisition: 0x1, 0x2 lock silently; 0x5, 0x6 accepted.
    send(4'h1, 1'b1, 1'b0, 1'b0);
    chk_out("lock_w1", 1'b0, 1'b0, 3'd0, 1'b0);
    send(4'h2, 1'b1, 1'b0, 1'b0);
    chk_out("lock_w2", 1'b0, 1'b1, 3'd0, 1'b0);
    send(4'h5, 1'b1, 1'b0, 1'b0);
    chk_out("lock_w3", 1'b1, 1'b1, 3'd2, 1'b1);
    send(4'h6, 1'b1, 1'b0, 1'b0);
    chk_out("lock_w4", 1'b1, 1'b1, 3'd3, 1'b0);
    chk_cnt("lock", 0, 1, 1);

    // Wrap: tags 4,5,6,7,0,1 all in sequence (exp now 4).
    send(4'h9, 1'b1, 1'b0, 1'b0);
    send(4'hA, 1'b1, 1'b0, 1'b0);
    send(4'hD, 1'b1, 1'b0, 1'b0);
    chk_out("wrap_t6", 1'b1, 1'b1, 3'd6, 1'b1);
    send(4'hE, 1'b1, 1'b0, 1'b0);
    chk_out("wrap_t7", 1'b1, 1'b1, 3'd7, 1'b0);
    send(4'h1, 1'b1, 1'b0, 1'b0);
    chk_out("wrap_t0", 1'b1, 1'b1, 3'd0, 1'b1);
    send(4'h2, 1'b1, 1'b0, 1'b0);
    chk_out("wrap_t1", 1'b1, 1'b1, 3'd1, 1'b0);
    chk_cnt("wrap", 0, 4, 4);

    // Flywheel: advance to exp=4, then tag 2 (miss) and tag 5 (accepted).
    send(4'h5, 1'b1, 1'b0, 1'b0);
    send(4'h6, 1'b1, 1'b0, 1'b0);
    send(4'h4, 1'b1, 1'b0, 1'b0);
    chk_out("fly_miss", 1'b0, 1'b1, 3'd3, 1'b0);
    chk("fly_miss.err", 32'(err_cnt), 32'd1);
    send(4'hB, 1'b1, 1'b0, 1'b0);
    chk_out("fly_hit", 1'b1, 1'b1, 3'd5, 1'b1);
    chk_cnt("fly", 1, 6, 5);

    // Loss: tags 6,7,0,1,2 (data 0) bring exp to 3, then tag 0 twice.
    send(4'hC, 1'b1, 1'b0, 1'b0);
    send(4'hE, 1'b1, 1'b0, 1'b0);
    send(4'h0, 1'b1, 1'b0, 1'b0);
    send(4'h2, 1'b1, 1'b0, 1'b0);
    send(4'h4, 1'b1, 1'b0, 1'b0);
    chk_out("pre_loss", 1'b1, 1'b1, 3'd2, 1'b0);
    send(4'h0, 1'b1, 1'b0, 1'b0);
    chk_out("loss_1", 1'b0, 1'b1, 3'd2, 1'b0);
    send(4'h0, 1'b1, 1'b0, 1'b0);
    chk_out("loss_2", 1'b0, 1'b0, 3'd2, 1'b0);
    chk_cnt("loss", 3, 6, 10);
    // Reacquire: tags 4,5 lock without acceptance, tag 6 accepted.
    send(4'h9, 1'b1, 1'b0, 1'b0);
    chk_out("reacq_1", 1'b0, 1'b0, 3'd2, 1'b0);
    send(4'hB, 1'b1, 1'b0, 1'b0);
    chk_out("reacq_2", 1'b0, 1'b1, 3'd2, 1'b0);
    send(4'hD, 1'b1, 1'b0, 1'b0);
    chk_out("reacq_3", 1'b1, 1'b1, 3'd6, 1'b1);
    chk_cnt("reacq", 3, 7, 10);

    // Gaps: in_valid low cycles carry a would-be word and must be ignored.
    send(4'hF, 1'b0, 1'b0, 1'b0);
    chk_out("gap_1", 1'b0, 1'b1, 3'd6, 1'b1);
    send(4'hF, 1'b1, 1'b0, 1'b0);
    chk_out("gap_v1", 1'b1, 1'b1, 3'd7, 1'b1);
    send(4'h1, 1'b0, 1'b0, 1'b0);
    chk_out("gap_2", 1'b0, 1'b1, 3'd7, 1'b1);
    send(4'h1, 1'b1, 1'b0, 1'b0);
    chk_out("gap_v2", 1'b1, 1'b1, 3'd0, 1'b1);
    chk_cnt("gap", 3, 9, 10);

    // clr_stats with an accepted word: counters zero, word still delivered.
    send(4'h3, 1'b1, 1'b1, 1'b0);
    chk_out("clr", 1'b1, 1'b1, 3'd1, 1'b1);
    chk_cnt("clr", 0, 0, 0);

    // Saturation: 300 accepted 1-bits starting at tag 2.
    t = 3'd2;
    for (int i = 0; i < 300; i++) begin
      send({t, 1'b1}, 1'b1, 1'b0, 1'b0);
      t = t + 3'd1;
    end
    chk_out("sat", 1'b1, 1'b1, 3'd5, 1'b1);
    chk_cnt("sat", 0, 255, 0);

    // Reset mid-lock with clr_stats and an in-sequence word (tag 6).
    send(4'hD, 1'b1, 1'b1, 1'b1);
    chk_out("rst_mid", 1'b0, 1'b0, 3'd0, 1'b0);
    chk_cnt("rst_mid", 0, 0, 0);
    send(4'hF, 1'b1, 1'b0, 1'b0);
    chk_out("rst_reacq_1", 1'b0, 1'b0, 3'd0, 1'b0);
    send(4'h1, 1'b1, 1'b0, 1'b0);
    chk_out("rst_reacq_2", 1'b0, 1'b1, 3'd0, 1'b0);
    send(4'h3, 1'b1, 1'b0, 1'b0);
    chk_out("rst_reacq_3", 1'b1, 1'b1, 3'd1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
